// File: rtl/pc_stack_if.sv
// pc_stack_if: command/status bundle between the control unit and pc_stack_unit.
//
// Commands (control unit -> pc_stack_unit):
//   write_pc   commit the next PC this cycle (one pulse per instruction)
//   branch     PC source: 00 pc+1, 01 imm_target, 10 imm_target if cond_flag, 11 reg_target
//   ret        with write_pc: load PC from the stack top (RET)
//   push       with write_pc: push pc+1 (CALL); without write_pc: push push_data (PUSH)
//   pop        without write_pc: move the stack top into pop_data (POP)
//   imm_target, reg_target, cond_flag, push_data  operands for the above
// Status (pc_stack_unit -> control unit / instruction memory):
//   pc, pop_data, stack_count, stack_empty, stack_full, overflow, underflow
//
// The RET command is carried on "ret" because "return" is a reserved word.
interface pc_stack_if #(
   parameter int PC_WIDTH    = 32,
   parameter int STACK_DEPTH = 8
) ();
   localparam int CNT_W = $clog2(STACK_DEPTH) + 1;

   logic                write_pc;
   logic [1:0]          branch;
   logic                ret;
   logic                push;
   logic                pop;
   logic [PC_WIDTH-1:0] imm_target;
   logic [PC_WIDTH-1:0] reg_target;
   logic                cond_flag;
   logic [PC_WIDTH-1:0] push_data;

   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] pop_data;
   logic [CNT_W-1:0]    stack_count;
   logic                stack_empty;
   logic                stack_full;
   logic                overflow;
   logic                underflow;

   modport master (
      output write_pc, branch, ret, push, pop,
             imm_target, reg_target, cond_flag, push_data,
      input  pc, pop_data, stack_count, stack_empty, stack_full,
             overflow, underflow
   );

   modport slave (
      input  write_pc, branch, ret, push, pop,
             imm_target, reg_target, cond_flag, push_data,
      output pc, pop_data, stack_count, stack_empty, stack_full,
             overflow, underflow
   );
endinterface

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: architectural PC plus a hardware return/data LIFO.
//
// Ports:
//   clk    core clock, all state updates on the rising edge
//   reset  synchronous, active-high; overrides every command in its cycle
//   bus    pc_stack_if.slave -- commands in, PC/stack status out
//
// At most one stack operation happens per cycle. Precedence:
//   write_pc=1: ret pops into pc (push ignored), else push is a CALL of pc+1;
//               pop is ignored.
//   write_pc=0: pop wins over push.
// Push on a full stack / pop on an empty stack leave the stack untouched and
// set the sticky overflow / underflow flags, which only reset clears.
module pc_stack_unit #(
   parameter int                  PC_WIDTH    = 32,
   parameter int                  STACK_DEPTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
   input logic        clk,
   input logic        reset,
   pc_stack_if.slave  bus
);
   localparam int PTR_W = $clog2(STACK_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] pop_data_q;
   logic [CNT_W-1:0]    count_q;
   logic                overflow_q;
   logic                underflow_q;

   logic                is_empty;
   logic                is_full;
   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] top;
   logic                do_ret;
   logic                do_call;
   logic                do_push;
   logic                do_pop;
   logic                push_req;
   logic                pop_req;
   logic                push_ok;
   logic                pop_ok;
   logic [PC_WIDTH-1:0] push_word;
   logic [PC_WIDTH-1:0] pc_next;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_W'(STACK_DEPTH));
   assign pc_inc   = pc_q + 1'b1;   // wraps modulo 2^PC_WIDTH
   // Top entry sits one below the count; only meaningful when non-empty.
   assign top      = stack_mem[PTR_W'(count_q - 1'b1)];

   // Decode the single stack operation allowed this cycle.
   assign do_ret   = bus.write_pc & bus.ret;
   assign do_call  = bus.write_pc & bus.push & ~bus.ret;
   assign do_pop   = ~bus.write_pc & bus.pop;
   assign do_push  = ~bus.write_pc & bus.push & ~bus.pop;
   assign push_req = do_call | do_push;
   assign pop_req  = do_ret | do_pop;
   assign push_ok  = push_req & ~is_full;
   assign pop_ok   = pop_req & ~is_empty;
   assign push_word = do_call ? pc_inc : bus.push_data;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      pc_next = pc_inc;
      if (bus.ret) begin
         // RET on an empty stack falls through to pc+1.
         if (!is_empty) pc_next = top;
      end else begin
         case (bus.branch)
            2'b01:   pc_next = bus.imm_target;
            2'b10:   pc_next = bus.cond_flag ? bus.imm_target : pc_inc;
            2'b11:   pc_next = bus.reg_target;
            default: pc_next = pc_inc;
         endcase
      end
   end

   // NOTE: the stack storage has no reset -- its contents are don't-care after
   // reset, and count_q alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (!reset && push_ok) stack_mem[count_q[PTR_W-1:0]] <= push_word;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         pop_data_q  <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.write_pc) pc_q <= pc_next;
         if (do_pop && !is_empty) pop_data_q <= top;
         if (push_ok)      count_q <= count_q + 1'b1;
         else if (pop_ok)  count_q <= count_q - 1'b1;
         if (push_req && is_full)  overflow_q  <= 1'b1;
         if (pop_req && is_empty)  underflow_q <= 1'b1;
      end
   end

   assign bus.pc          = pc_q;
   assign bus.pop_data    = pop_data_q;
   assign bus.stack_count = count_q;
   assign bus.stack_empty = is_empty;
   assign bus.stack_full  = is_full;
   assign bus.overflow    = overflow_q;
   assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed test-plan steps followed by random commands,
// checked against a queue-based reference model of the PC/stack rules.
module tb_pc_stack_unit;
   localparam int PW    = 32;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pc_stack_if #(.PC_WIDTH(PW), .STACK_DEPTH(DEPTH)) bus ();

   pc_stack_unit #(.PC_WIDTH(PW), .STACK_DEPTH(DEPTH), .RESET_PC('0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Reference model
   logic [PW-1:0] m_pc;
   logic [PW-1:0] m_pop_data;
   logic [PW-1:0] m_stack[$];
   logic          m_ovf;
   logic          m_unf;

   int n_vectors    = 0;
   int n_miscompare = 0;

   task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      n_vectors++;
      assert (obs === exp) else begin
         n_miscompare++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"},       bus.pc, m_pc);
      check({tag, ".pop_data"}, bus.pop_data, m_pop_data);
      check({tag, ".count"},    PW'(bus.stack_count), PW'(m_stack.size()));
      check({tag, ".empty"},    PW'(bus.stack_empty), PW'(m_stack.size() == 0));
      check({tag, ".full"},     PW'(bus.stack_full), PW'(m_stack.size() == DEPTH));
      check({tag, ".ovf"},      PW'(bus.overflow), PW'(m_ovf));
      check({tag, ".unf"},      PW'(bus.underflow), PW'(m_unf));
   endtask

   function automatic void model_step(input logic rst, input logic wp, input logic [1:0] br,
                                      input logic rt, input logic ps, input logic pp,
                                      input logic [PW-1:0] imm, input logic [PW-1:0] rg,
                                      input logic cf, input logic [PW-1:0] pd);
      logic [PW-1:0] next;
      if (rst) begin
         m_pc = '0; m_pop_data = '0; m_stack.delete(); m_ovf = 0; m_unf = 0;
         return;
      end
      if (wp) begin
         next = m_pc + 1;
         if (rt) begin
            if (m_stack.size() > 0) next = m_stack.pop_back();
            else m_unf = 1;
         end else begin
            if (br == 2'b01) next = imm;
            else if (br == 2'b10 && cf) next = imm;
            else if (br == 2'b11) next = rg;
            if (ps) begin
               if (m_stack.size() < DEPTH) m_stack.push_back(m_pc + 1);
               else m_ovf = 1;
            end
         end
         m_pc = next;
      end else if (pp) begin
         if (m_stack.size() > 0) m_pop_data = m_stack.pop_back();
         else m_unf = 1;
      end else if (ps) begin
         if (m_stack.size() < DEPTH) m_stack.push_back(pd);
         else m_ovf = 1;
      end
   endfunction

   // Drive one cycle of commands at the falling edge, advance the model at the
   // rising edge, then compare everything shortly after.
   task automatic cmd(input string tag, input logic rst, input logic wp, input logic [1:0] br,
                      input logic rt, input logic ps, input logic pp,
                      input logic [PW-1:0] imm, input logic [PW-1:0] rg,
                      input logic cf, input logic [PW-1:0] pd);
      @(negedge clk);
      reset = rst;
      bus.write_pc = wp; bus.branch = br; bus.ret = rt; bus.push = ps; bus.pop = pp;
      bus.imm_target = imm; bus.reg_target = rg; bus.cond_flag = cf; bus.push_data = pd;
      @(posedge clk);
      model_step(rst, wp, br, rt, ps, pp, imm, rg, cf, pd);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      cmd(tag, 0, 0, 2'b00, 0, 0, 0, '0, '0, 0, '0);
   endtask
   task automatic seq(input string tag);
      cmd(tag, 0, 1, 2'b00, 0, 0, 0, '0, '0, 0, '0);
   endtask
   task automatic do_reset(input string tag);
      cmd(tag, 1, 0, 2'b00, 0, 0, 0, '0, '0, 0, '0);
   endtask

   initial begin
      reset = 1'b1;
      bus.write_pc = 0; bus.branch = '0; bus.ret = 0; bus.push = 0; bus.pop = 0;
      bus.imm_target = '0; bus.reg_target = '0; bus.cond_flag = 0; bus.push_data = '0;
      m_pc = '0; m_pop_data = '0; m_ovf = 0; m_unf = 0;

      // Reset and sequential stepping with idle gaps
      do_reset("reset");
      check("reset_pc_const", bus.pc, 32'h0);
      for (int i = 0; i < 3; i++) begin
         seq("seq");
         idle("seq_idle");
      end
      check("seq_pc3_const", bus.pc, 32'h3);

      // Conditional branch not taken / taken from pc=5
      seq("to5a"); seq("to5b");
      cmd("br_nt", 0, 1, 2'b10, 0, 0, 0, 32'h40, '0, 0, '0);
      check("br_nt_const", bus.pc, 32'h6);
      do_reset("reset2");
      for (int i = 0; i < 5; i++) seq("to5");
      cmd("br_t", 0, 1, 2'b10, 0, 0, 0, 32'h40, '0, 1, '0);
      check("br_t_const", bus.pc, 32'h40);

      // CALL from 0x10 then RET
      cmd("jr", 0, 1, 2'b11, 0, 0, 0, '0, 32'h10, 0, '0);
      cmd("call", 0, 1, 2'b01, 0, 1, 0, 32'h80, '0, 0, '0);
      check("call_pc_const", bus.pc, 32'h80);
      cmd("ret", 0, 1, 2'b00, 1, 0, 0, '0, '0, 0, '0);
      check("ret_pc_const", bus.pc, 32'h11);

      // Fill, overflow, drain
      for (int i = 0; i < DEPTH; i++) cmd("push", 0, 0, 2'b00, 0, 1, 0, '0, '0, 0, 32'hA0 + i);
      cmd("push_ovf", 0, 0, 2'b00, 0, 1, 0, '0, '0, 0, 32'hEE);
      check("ovf_const", PW'(bus.overflow), 32'h1);
      for (int i = 0; i < DEPTH; i++) cmd("pop", 0, 0, 2'b00, 0, 0, 1, '0, '0, 0, '0);
      check("last_pop_const", bus.pop_data, 32'hA0);

      // Underflow via RET and POP from pc=0x20
      cmd("jmp20", 0, 1, 2'b01, 0, 0, 0, 32'h20, '0, 0, '0);
      cmd("ret_empty", 0, 1, 2'b00, 1, 0, 0, '0, '0, 0, '0);
      check("ret_empty_const", bus.pc, 32'h21);
      cmd("pop_empty", 0, 0, 2'b00, 0, 0, 1, '0, '0, 0, '0);

      // push+pop together, RET with push, CALL-with-pop, then reset mid-CALL
      cmd("push33", 0, 0, 2'b00, 0, 1, 0, '0, '0, 0, 32'h33);
      cmd("push_pop", 0, 0, 2'b00, 0, 1, 1, '0, '0, 0, 32'h55);
      check("push_pop_const", bus.pop_data, 32'h33);
      cmd("call_a", 0, 1, 2'b01, 0, 1, 0, 32'h100, '0, 0, '0);
      cmd("ret_push", 0, 1, 2'b00, 1, 1, 0, '0, '0, 0, '0);
      cmd("call_pop", 0, 1, 2'b11, 0, 1, 1, '0, 32'h200, 0, '0);
      cmd("rst_call", 1, 1, 2'b01, 0, 1, 0, 32'h80, '0, 0, '0);

      // PC wrap
      cmd("jmp_max", 0, 1, 2'b11, 0, 0, 0, '0, 32'hFFFF_FFFF, 0, '0);
      seq("wrap");
      check("wrap_const", bus.pc, 32'h0);

      // Random commands, occasional reset
      for (int i = 0; i < 400; i++) begin
         cmd("rand", ($urandom_range(0, 49) == 0), $urandom_range(0, 1), 2'($urandom),
             ($urandom_range(0, 3) == 0), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
             $urandom, $urandom, $urandom_range(0, 1), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
      $finish;
   end
endmodule
